// File: rtl/addsub_serial.sv
// Multi-cycle add/subtract unit: one DIGIT-wide adder slice is reused N = WIDTH/DIGIT times
// per operation. It uses a start/busy/done handshake and produces carry, overflow, zero and negative flags.
module addsub_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             s,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d;

  logic [DIGIT:0]       dsum;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]     res_shift;
  logic                 msb_cin;
  logic                 last_digit;

  assign dsum       = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
  // Carry into a bit position is recovered as a ^ b ^ sum of that bit.
  assign msb_cin    = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum[DIGIT-1];
  assign res_cat    = {dsum[DIGIT-1:0], res_q};
  assign res_shift  = res_cat[WIDTH+DIGIT-1:DIGIT];
  assign last_digit = (cnt_q == CNT_W'(N - 1));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{s}};
          carry_d = s;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          a_d     = a_q >> DIGIT;
          b_d     = b_q >> DIGIT;
          res_d   = res_shift;
          carry_d = dsum[DIGIT];
          cnt_d   = cnt_q + CNT_W'(1);
          if (last_digit) begin
            state_d  = DONE;
            result_d = res_shift;
            cout_d   = dsum[DIGIT];
            ovf_d    = msb_cin ^ dsum[DIGIT];
            zero_d   = (res_shift == '0);
            neg_d    = res_shift[WIDTH-1];
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;
  assign zero   = zero_q;
  assign neg    = neg_q;

endmodule

// File: doc/addsub_serial.md
Name: addsub_serial

Overview:
- Parametrised multi-cycle add/subtract unit for the calculator datapath.
- Processes WIDTH-bit operands DIGIT bits per clock through one shared DIGIT-wide adder slice, trading latency for area.
- Uses a start/busy/done handshake.
- Produces result, unsigned carry/borrow, signed overflow, zero and negative flags for the display/ALU control FSM.

Parameters:
- WIDTH, 8, operand/result width in bits. Must be ≥ 2 and a multiple of DIGIT.
- DIGIT, 2, bits processed per clock. Must be 1..WIDTH. N = WIDTH/DIGIT is the digit count.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a new operation; sampled only in IDLE.
- abort  in  1  synchronous cancel of an operation in progress.
- s  in  1  operation select: 0 = add (A+B), 1 = subtract (A−B).
- a  in  WIDTH  operand A; captured when start is accepted.
- b  in  WIDTH  operand B; captured when start is accepted.
- busy  out  1  high while the operation is running (RUN state).
- done  out  1  one-cycle pulse; result and flags are valid from this cycle.
- result  out  WIDTH  sum or difference, modulo 2^WIDTH.
- cout  out  1  final carry. For subtract, 1 = no borrow (A ≥ B unsigned).
- ovf  out  1  two's-complement overflow.
- zero  out  1  result == 0.
- neg  out  1  result[WIDTH-1].

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE. busy, done, result, cout, ovf, zero and neg all 0. Internal operand registers, carry and digit counter all cleared. A reset in the middle of an operation discards it with no done pulse.
- States:
  - IDLE: busy=0. If start=1, latch a, and b XOR {WIDTH{s}}, into shift registers. Set carry register = s and counter = 0, then go to RUN. If start=0, stay in IDLE.
  - RUN: busy=1. Each cycle, add the low DIGIT bits of both operand registers plus the carry. Shift the sum digit into the result shift register from the MSB side and shift the operands right by DIGIT. Update the carry and increment the counter. When the digit with counter == N−1 is processed, go to DONE.
  - DONE: done=1, busy=0 for exactly one cycle, then go to IDLE.
- Latency: start accepted at edge k → busy=1 after edge k → done=1 after edge k+N, lasting one cycle → IDLE after edge k+N+1. The minimum start-to-start spacing is N+2 cycles.
- Output registers: result, cout, ovf, zero and neg update only at the edge entering DONE. They hold their values until the next DONE entry or reset; accepting a new start does not clear them.
- ovf is computed from the final digit as carry-into-MSB XOR carry-out-of-MSB, where the MSB is that of the effective operand B XOR s.
- start is ignored while in RUN or DONE, including a start held high continuously. Changes to a, b or s after acceptance have no effect on the operation in progress.
- abort=1 in RUN: go to IDLE at the next edge. No done pulse; output registers keep their previous values. abort is ignored in IDLE and DONE.
- If start and abort are both high in IDLE, start is accepted; abort has no effect in IDLE.
- DIGIT == WIDTH (N=1): RUN lasts a single cycle, and done follows one cycle after it.
- Arithmetic: result = (A + (B XOR {WIDTH{s}}) + s) mod 2^WIDTH. No saturation.

Test Plan:
- WIDTH=8, DIGIT=2: s=0, a=8'h7F, b=8'h01, pulse start → busy high for 4 cycles, done after 4 edges; result=8'h80, cout=0, ovf=1, neg=1, zero=0.
- s=1, a=8'h05, b=8'h05 → result=8'h00, cout=1, zero=1, ovf=0, neg=0. Then s=1, a=8'h03, b=8'h05 → result=8'hFE, cout=0, neg=1, ovf=0.
- s=0, a=8'hFF, b=8'h01 → result=8'h00, cout=1, zero=1, ovf=0. Also s=1, a=8'h80, b=8'h01 → result=8'h7F, ovf=1, cout=1.
- Hold start high and change a/b every cycle during RUN → exactly one done per N+2 cycles, and result matches the operands latched at acceptance.
- Assert abort on the 2nd RUN cycle → busy falls next edge, no done pulse, result unchanged. Drive rst_n=0 mid-RUN → all outputs read 0 immediately, without waiting for a clock edge.
- WIDTH=16, DIGIT=16 and WIDTH=16, DIGIT=1 with a randomized 1000-operation run against a reference model → results and flags match, and latency is 1 and 16 cycles respectively.
